// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state codes, RV32I opcodes, alu_op and mux-select codes
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;
  localparam logic [1:0] B_RS2 = 2'b00;
  localparam logic [1:0] B_IMM = 2'b01;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  function automatic logic is_rv32i(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                      OP_STORE, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM};
  endfunction
endpackage

// File: rtl/mc_ctrl_mem_wdog.sv
// mem_wdog: counts consecutive stalled memory cycles; ports clk, rst_n, req, ready -> expired
module mem_wdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic expired
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] cnt;
  logic clear;
  assign clear = !req || ready;
  // cnt holds the number of prior stalled cycles, so the MEM_TIMEOUT-th stall fires here
  assign expired = !clear && (cnt == W'(MEM_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle RV32I control FSM; ports clk, rst_n, opcode, br_taken, mem_ready -> memory/datapath strobes, selects, status, state
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);
  state_t st, nx;
  logic expired;
  assign state    = st;
  assign mem_req  = (st == S_FETCH) || (st == S_MEM);
  assign addr_sel = st == S_MEM;
  assign halted   = st == S_HALT;
  assign fault    = st == S_FAULT;
  mem_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk(clk), .rst_n(rst_n), .req(mem_req), .ready(mem_ready), .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= S_FETCH;
    else st <= nx;
  always_comb begin
    nx = st;
    mem_we = 1'b0;
    ir_we = 1'b0;
    pc_we = 1'b0;
    rf_we = 1'b0;
    pc_sel = PC_PLUS4;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    alu_op = ALU_ADD;
    wb_sel = WB_ALU;
    case (st)
      S_FETCH: begin
        ir_we = mem_ready;
        nx = mem_ready ? S_DECODE : expired ? S_FAULT : S_FETCH;
      end
      S_DECODE:
        nx = opcode == OP_SYSTEM ? S_HALT : opcode == OP_FENCE ? S_WB :
             !is_rv32i(opcode) ? S_FAULT : S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_OP: alu_op = ALU_R;
          OP_OPIMM: begin alu_b_sel = B_IMM; alu_op = ALU_I; end
          OP_LUI: begin alu_a_sel = A_ZERO; alu_b_sel = B_IMM; end
          OP_AUIPC: begin alu_a_sel = A_PC; alu_b_sel = B_IMM; end
          OP_LOAD, OP_STORE, OP_JALR: alu_b_sel = B_IMM;
          OP_BRANCH: begin
            alu_op = ALU_SUB;
            pc_we = 1'b1;
            pc_sel = br_taken ? PC_IMM : PC_PLUS4;
          end
          default: ;
        endcase
        nx = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM :
             opcode == OP_BRANCH ? S_FETCH : S_WB;
      end
      S_MEM: begin
        mem_we = opcode == OP_STORE;
        pc_we = (opcode == OP_STORE) && mem_ready;
        nx = mem_ready ? (opcode == OP_STORE ? S_FETCH : S_WB) : expired ? S_FAULT : S_MEM;
      end
      S_WB: begin
        pc_we = 1'b1;
        nx = S_FETCH;
        case (opcode)
          OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: rf_we = 1'b1;
          OP_LOAD: begin rf_we = 1'b1; wb_sel = WB_MEM; end
          OP_JAL: begin rf_we = 1'b1; wb_sel = WB_PC4; pc_sel = PC_IMM; end
          OP_JALR: begin rf_we = 1'b1; wb_sel = WB_PC4; pc_sel = PC_ALU; alu_b_sel = B_IMM; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule
